sobel_window_3x3: RTL and testbench

// - Downstream of the three-line buffer. Takes the live pixel stream plus the two buffered rows (y-2, y-1).
// - Builds a 3x3 luma window and computes the Sobel edge magnitude |Gx|+|Gy|.
// - Emits one magnitude pixel per input pixel, with sync/coords delay-matched. Feeds the overlay/detection stages.

---
 rtl/img_pkg.sv | 24 ++
 rtl/sobel_window_3x3_if.sv | 26 ++
 rtl/sobel_kernel.sv | 46 ++++
 rtl/sobel_window_3x3.sv | 82 ++++++++
 tb/tb_sobel_window_3x3.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/img_pkg.sv
// Shared pixel types, luma coefficients and the RGB->luma helper for the
// edge-detection path.
package img_pkg;
  localparam logic [7:0] LUMA_R    = 8'd77;
  localparam logic [7:0] LUMA_G    = 8'd150;
  localparam logic [7:0] LUMA_B    = 8'd29;
  localparam int         SOBEL_LAT = 5;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef logic [7:0]         luma_t;
  typedef logic signed [10:0] grad_t;

  // Coefficients sum to 256, so the 16-bit sum cannot overflow and >>8 yields 0..255.
  function automatic luma_t rgb2luma(rgb_t p);
    logic [15:0] acc;
    acc = 16'(LUMA_R) * 16'(p.r) + 16'(LUMA_G) * 16'(p.g) + 16'(LUMA_B) * 16'(p.b);
    return acc[15:8];
  endfunction
endpackage

// File: rtl/sobel_window_3x3_if.sv
// Pixel stream in (live pixel plus two buffered rows) and edge stream out.
interface sobel_window_3x3_if
  import img_pkg::*;
#(
  parameter int XW = 11,
  parameter int YW = 10
);
  logic          i_hsync, i_vsync, i_de;
  rgb_t          i_rgb;
  logic [XW-1:0] i_x;
  logic [YW-1:0] i_y;
  rgb_t          line1, line2;
  logic          o_hsync, o_vsync, o_de;
  logic [7:0]    o_mag;
  logic [XW-1:0] o_x;
  logic [YW-1:0] o_y;

  modport master (
    output i_hsync, i_vsync, i_de, i_rgb, i_x, i_y, line1, line2,
    input  o_hsync, o_vsync, o_de, o_mag, o_x, o_y
  );
  modport slave (
    input  i_hsync, i_vsync, i_de, i_rgb, i_x, i_y, line1, line2,
    output o_hsync, o_vsync, o_de, o_mag, o_x, o_y
  );
endinterface

// File: rtl/sobel_kernel.sv
// 3x3 Sobel core: registered Gx/Gy, then registered |Gx|+|Gy| (saturated or binarised).
module sobel_kernel
  import img_pkg::*;
#(
  parameter logic [7:0] THRESH = 8'd64,
  parameter bit         BINARY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  luma_t [2:0][2:0]  win,   // [row][col], row 0 = oldest line, col 0 = oldest pixel
  output luma_t             mag
);
  grad_t       gx_c, gy_c, gx, gy;
  logic [10:0] ax, ay, sum;
  luma_t       mag_c;

  function automatic grad_t w3(luma_t a, luma_t b, luma_t c);
    return grad_t'({3'b000, a}) + grad_t'({2'b00, b, 1'b0}) + grad_t'({3'b000, c});
  endfunction

  always_comb begin
    gx_c = w3(win[0][2], win[1][2], win[2][2]) - w3(win[0][0], win[1][0], win[2][0]);
    gy_c = w3(win[2][0], win[2][1], win[2][2]) - w3(win[0][0], win[0][1], win[0][2]);
  end

  assign ax  = gx[10] ? $unsigned(-gx) : $unsigned(gx);
  assign ay  = gy[10] ? $unsigned(-gy) : $unsigned(gy);
  assign sum = ax + ay;

  always_comb begin
    if (BINARY) mag_c = (sum >= {3'b000, THRESH}) ? 8'hFF : 8'h00;
    else        mag_c = (sum > 11'd255) ? 8'hFF : sum[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gx  <= '0;
      gy  <= '0;
      mag <= '0;
    end else begin
      gx  <= gx_c;
      gy  <= gy_c;
      mag <= mag_c;
    end
  end
endmodule

// File: rtl/sobel_window_3x3.sv
// Builds a 3x3 luma window from the live pixel and two buffered rows and emits
// the Sobel edge magnitude with sync/coords delayed by SOBEL_LAT clocks.
module sobel_window_3x3
  import img_pkg::*;
#(
  parameter logic [11:0] H_ACT  = 12'd1280,
  parameter logic [11:0] V_ACT  = 12'd720,
  parameter logic [7:0]  THRESH = 8'd64,
  parameter bit          BINARY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  sobel_window_3x3_if.slave bus
);
  localparam int XW = $clog2(H_ACT);
  localparam int YW = $clog2(V_ACT);

  typedef struct packed {
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } ctl_t;

  // Stage k of the sync/coord delay line is ctl_pipe[k] (S0..S4).
  ctl_t [SOBEL_LAT-1:0] ctl_pipe;
  ctl_t                 ctl_in;
  rgb_t                 px_s0;
  luma_t [2:0]          luma_s1;   // [0]=y-2, [1]=y-1, [2]=y
  luma_t [2:0][2:0]     win;       // [row][col]
  luma_t                kmag;
  logic                 clr;

  always_comb begin
    ctl_in       = '0;
    ctl_in.hsync = bus.i_hsync;
    ctl_in.vsync = bus.i_vsync;
    ctl_in.de    = bus.i_de;
    ctl_in.x     = bus.i_x;
    ctl_in.y     = bus.i_y;
  end

  // Start of line or frame: drop whatever the window held from before.
  assign clr = ctl_pipe[1].vsync | (ctl_pipe[1].de & ~ctl_pipe[2].de);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_pipe <= '0;
      px_s0    <= '0;
      luma_s1  <= '0;
      win      <= '0;
    end else begin
      ctl_pipe <= {ctl_pipe[SOBEL_LAT-2:0], ctl_in};
      px_s0    <= bus.i_rgb;
      luma_s1  <= {rgb2luma(px_s0), rgb2luma(bus.line2), rgb2luma(bus.line1)};
      if (ctl_pipe[1].de) begin
        for (int r = 0; r < 3; r++)
          win[r] <= clr ? {luma_s1[r], 16'd0} : {luma_s1[r], win[r][2:1]};
      end else if (clr) begin
        win <= '0;
      end
    end
  end

  sobel_kernel #(.THRESH(THRESH), .BINARY(BINARY)) u_kernel (
    .clk (clk),
    .rst (rst),
    .win (win),
    .mag (kmag)
  );

  assign bus.o_hsync = ctl_pipe[SOBEL_LAT-1].hsync;
  assign bus.o_vsync = ctl_pipe[SOBEL_LAT-1].vsync;
  assign bus.o_de    = ctl_pipe[SOBEL_LAT-1].de;
  assign bus.o_x     = ctl_pipe[SOBEL_LAT-1].x;
  assign bus.o_y     = ctl_pipe[SOBEL_LAT-1].y;
  // Border and blanking masks: no complete window exists for x<2 or y<2.
  assign bus.o_mag   = (ctl_pipe[SOBEL_LAT-1].de &&
                        ctl_pipe[SOBEL_LAT-1].x >= XW'(2) &&
                        ctl_pipe[SOBEL_LAT-1].y >= YW'(2)) ? kmag : 8'd0;
endmodule

// File: tb/tb_sobel_window_3x3.sv
// Scoreboard bench: stimulus pushes hand-derived expectations, a negedge monitor
// pops and compares them against a saturating and a binarising instance.
module tb_sobel_window_3x3;
  import img_pkg::*;
  localparam int XW = 11, YW = 10;
  localparam int T_GREY = 0, T_VSTEP = 1, T_HSTEP = 2, T_RAMP5 = 3, T_RAMP10 = 4, T_RAND = 5;

  typedef struct {
    int       x, y, cyc;
    bit       care;
    logic [7:0] sat, bin;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_chk = 0, n_pass = 0;
  int   cur_t = T_GREY;
  exp_t sb[$];
  logic [2:0] hist [64];
  rgb_t rnd_img [4][10];
  rgb_t nxt_l1, nxt_l2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sobel_window_3x3_if #(.XW(XW), .YW(YW)) bus ();
  sobel_window_3x3_if #(.XW(XW), .YW(YW)) bus_b ();

  assign bus_b.i_hsync = bus.i_hsync;
  assign bus_b.i_vsync = bus.i_vsync;
  assign bus_b.i_de    = bus.i_de;
  assign bus_b.i_rgb   = bus.i_rgb;
  assign bus_b.i_x     = bus.i_x;
  assign bus_b.i_y     = bus.i_y;
  assign bus_b.line1   = bus.line1;
  assign bus_b.line2   = bus.line2;

  sobel_window_3x3 #(.H_ACT(12'd1280), .V_ACT(12'd720), .THRESH(8'd64), .BINARY(1'b0))
    dut (.clk(clk), .rst(rst), .bus(bus));
  sobel_window_3x3 #(.H_ACT(12'd1280), .V_ACT(12'd720), .THRESH(8'd64), .BINARY(1'b1))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  function automatic rgb_t grey(int v);
    rgb_t p;
    p.r = 8'(v); p.g = 8'(v); p.b = 8'(v);
    return p;
  endfunction

  function automatic rgb_t pix(int t, int x, int y);
    if (y < 0) return '0;
    case (t)
      T_GREY:   return grey(128);
      T_VSTEP:  return grey(x < 640 ? 0 : 255);
      T_HSTEP:  return grey(y < 100 ? 0 : 255);
      T_RAMP5:  return grey(5 * x);
      T_RAMP10: return grey(10 * x);
      default:  return (y < 4 && x < 10) ? rnd_img[y][x] : '0;
    endcase
  endfunction

  // Hand rules for the output whose window is centred on (x-1, y-1).
  function automatic void exp_rule(input int t, input int x, input int y,
                                   output bit care, output logic [7:0] sat);
    care = 1'b1;
    sat  = 8'd0;
    if (x < 2 || y < 2) return;
    case (t)
      T_VSTEP:  sat = (x == 640 || x == 641) ? 8'd255 : 8'd0;
      T_HSTEP:  sat = (y == 100 || y == 101) ? 8'd255 : 8'd0;
      T_RAMP5:  sat = 8'd40;
      T_RAMP10: sat = 8'd80;
      T_RAND:   care = 1'b0;
      default:  sat = 8'd0;
    endcase
  endfunction

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // One clock slot: present the pixel and the line-buffer rows of the previous slot.
  task automatic drive(input logic hs, input logic vs, input logic de, input int x, input int y);
    exp_t e;
    @(posedge clk); #1;
    bus.line1   = nxt_l1;
    bus.line2   = nxt_l2;
    bus.i_hsync = hs;
    bus.i_vsync = vs;
    bus.i_de    = de;
    bus.i_rgb   = de ? pix(cur_t, x, y) : '0;
    bus.i_x     = XW'(x);
    bus.i_y     = YW'(y);
    hist[cyc % 64] = {hs, vs, de};
    if (de) begin
      e.x = x; e.y = y; e.cyc = cyc;
      exp_rule(cur_t, x, y, e.care, e.sat);
      e.bin = (e.sat >= 8'd64) ? 8'hFF : 8'h00;
      sb.push_back(e);
    end
    nxt_l1 = de ? pix(cur_t, x, y - 2) : '0;
    nxt_l2 = de ? pix(cur_t, x, y - 1) : '0;
  endtask

  task automatic run_rows(input int t, input int y0, input int y1, input int w);
    cur_t = t;
    for (int y = y0; y <= y1; y++) begin
      for (int x = 0; x < w; x++) drive(1'b0, 1'b0, 1'b1, x, y);
      drive(1'b1, 1'b0, 1'b0, 0, 0);
      drive(1'b1, 1'b0, 1'b0, 0, 0);
      drive(1'b0, 1'b0, 1'b0, 0, 0);
      drive(1'b0, 1'b0, 1'b0, 0, 0);
    end
  endtask

  task automatic vsync_pulse();
    drive(1'b0, 1'b1, 1'b0, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  // Everything in flight is discarded by the reset, so expectations go too.
  task automatic reset_pulse();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.i_hsync = 1'b0; bus.i_vsync = 1'b0; bus.i_de = 1'b0;
    bus.i_rgb = '0; bus.line1 = '0; bus.line2 = '0;
    nxt_l1 = '0; nxt_l2 = '0;
    foreach (hist[i]) hist[i] = 3'b000;
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk({bus.o_hsync, bus.o_vsync, bus.o_de} == 3'b000 && bus.o_mag == 8'd0 &&
          bus.o_x == '0 && bus.o_y == '0 && bus_b.o_de == 1'b0 && bus_b.o_mag == 8'd0,
          "rst_zero", {bus.o_de, bus.o_mag}, 0);
    end else begin
      if (cyc >= 5)
        chk({bus.o_hsync, bus.o_vsync, bus.o_de} == hist[(cyc - 5) % 64], "sync_delay",
            {bus.o_hsync, bus.o_vsync, bus.o_de}, hist[(cyc - 5) % 64]);
      if (bus.o_de) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_out", bus.o_x, -1);
        end else begin
          e = sb.pop_front();
          chk(int'(bus.o_x) == e.x, "o_x", bus.o_x, e.x);
          chk(int'(bus.o_y) == e.y, "o_y", bus.o_y, e.y);
          chk(cyc - e.cyc == SOBEL_LAT, "latency", cyc - e.cyc, SOBEL_LAT);
          if (e.care) begin
            chk(bus.o_mag == e.sat, "mag_sat", bus.o_mag, e.sat);
            chk(bus_b.o_mag == e.bin, "mag_bin", bus_b.o_mag, e.bin);
          end
        end
      end else begin
        chk(bus.o_mag == 8'd0 && bus_b.o_mag == 8'd0, "blank_zero", bus.o_mag, 0);
      end
    end
  end

  initial begin
    foreach (hist[i]) hist[i] = 3'b000;
    bus.i_hsync = 1'b0; bus.i_vsync = 1'b0; bus.i_de = 1'b0;
    bus.i_rgb = '0; bus.i_x = '0; bus.i_y = '0;
    bus.line1 = '0; bus.line2 = '0;
    nxt_l1 = '0; nxt_l2 = '0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run_rows(T_GREY, 0, 3, 10);
    vsync_pulse();
    run_rows(T_VSTEP, 0, 3, 660);
    vsync_pulse();
    run_rows(T_HSTEP, 97, 102, 10);
    run_rows(T_RAMP5, 4, 5, 41);
    run_rows(T_RAMP10, 4, 5, 26);
    vsync_pulse();
    foreach (rnd_img[y, x]) rnd_img[y][x] = rgb_t'($urandom);
    run_rows(T_RAND, 0, 3, 10);

    // Mid-line reset, then a fresh line must come out correct.
    cur_t = T_HSTEP;
    for (int x = 0; x < 300; x++) drive(1'b0, 1'b0, 1'b1, x, 100);
    reset_pulse();
    drive(1'b0, 1'b0, 1'b0, 0, 0);
    run_rows(T_HSTEP, 100, 101, 10);

    repeat (10) drive(1'b0, 1'b0, 1'b0, 0, 0);
    @(posedge clk); #1;
    chk(sb.size() == 0, "drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
